// File: rtl/add_accumulator_pkg.sv
// Shared definitions for the streaming add accumulator: FSM state type and
// default datapath widths.
package add_pkg;

    // Two-state frame controller: summing operands, or presenting a result.
    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam int DEFAULT_WIDTH = 4;
    localparam int DEFAULT_CNT_W = 4;

endpackage : add_pkg

// File: rtl/add_accumulator_carry_chain_adder.sv
// Ripple-carry adder built from WIDTH chained full adders.
module carry_chain_adder #(
    parameter int WIDTH = add_pkg::DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] carry;

    assign carry[0] = cin;

    // One full adder per bit; each stage's carry feeds the next.
    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign sum[i]     = a[i] ^ b[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign cout = carry[WIDTH];

endmodule : carry_chain_adder

// File: rtl/add_accumulator.sv
// Streaming multi-operand accumulator: sums one operand per cycle over a
// valid/ready input and presents total, sticky carry and operand count on a
// valid/ready output once the frame's last operand has been absorbed.
module add_accumulator
    import add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry,
    output logic [CNT_W-1:0] out_count
);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic [WIDTH-1:0]   add_sum;
    logic               add_cout;

    // Single adder shared by every beat; acc is zero at frame start, so the
    // first beat's carry-out is naturally zero.
    carry_chain_adder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .a    (acc_q),
        .b    (in_data),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Handshake outputs are decoded from state alone, so neither ready nor
    // valid has a combinational path from the opposite side.
    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == HOLD);

    assign out_sum   = acc_q;
    assign out_carry = carry_q;
    assign out_count = count_q;

    // Next-state logic for the frame controller and accumulation registers.
    always_comb begin
        // NOTE: every signal gets a default up front so no path through the
        // case leaves one unassigned, which would infer a latch.
        state_d = state_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        count_d = count_q;

        case (state_q)
            ACCUM: begin
                if (in_valid) begin
                    acc_d   = add_sum;
                    carry_d = carry_q | add_cout;
                    if (count_q != {CNT_W{1'b1}}) begin
                        count_d = count_q + CNT_W'(1);
                    end
                    if (in_last) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    acc_d   = '0;
                    carry_d = 1'b0;
                    count_d = '0;
                    state_d = ACCUM;
                end
            end
            default: begin
                state_d = ACCUM;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its pre-edge value regardless of statement order.
        if (rst) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            carry_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            count_q <= count_d;
        end
    end

endmodule : add_accumulator

// File: tb/tb_add_accumulator.sv
// Self-checking bench for add_accumulator: a frame-level reference model
// (running integer total, operand tally, pending-result flag) compared with
// the DUT on every falling edge, plus hand-computed literal checks.
module tb_add_accumulator;

    localparam int W      = 4;
    localparam int CW_A   = 4;
    localparam int CW_B   = 2;

    logic clk;
    logic rst;

    // Main DUT (CNT_W=4)
    logic          a_in_valid, a_in_ready, a_in_last, a_out_valid, a_out_ready, a_out_carry;
    logic [W-1:0]  a_in_data, a_out_sum;
    logic [CW_A-1:0] a_out_count;

    // Saturation DUT (CNT_W=2)
    logic          b_in_valid, b_in_ready, b_in_last, b_out_valid, b_out_ready, b_out_carry;
    logic [W-1:0]  b_in_data, b_out_sum;
    logic [CW_B-1:0] b_out_count;

    int n_vec = 0;
    int n_err = 0;

    add_accumulator #(.WIDTH(W), .CNT_W(CW_A)) dut_a (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_data   (a_in_data),
        .in_last   (a_in_last),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_sum   (a_out_sum),
        .out_carry (a_out_carry),
        .out_count (a_out_count)
    );

    add_accumulator #(.WIDTH(W), .CNT_W(CW_B)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_data   (b_in_data),
        .in_last   (b_in_last),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_sum   (b_out_sum),
        .out_carry (b_out_carry),
        .out_count (b_out_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int actual, input int expected);
        n_vec++;
        if (actual !== expected) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // ---------------- frame-level reference model ----------------
    // The true integer total of the frame gives the sum (mod 2^W) and the
    // sticky carry (any wrap happened iff the total reached 2^W).
    int a_total = 0, a_n = 0;  bit a_hold = 0;
    int b_total = 0, b_n = 0;  bit b_hold = 0;

    always @(posedge clk) begin
        if (rst) begin
            a_total = 0; a_n = 0; a_hold = 0;
            b_total = 0; b_n = 0; b_hold = 0;
        end else begin
            if (!a_hold) begin
                if (a_in_valid) begin
                    a_total += int'(a_in_data);
                    a_n++;
                    if (a_in_last) a_hold = 1;
                end
            end else if (a_out_ready) begin
                a_total = 0; a_n = 0; a_hold = 0;
            end
            if (!b_hold) begin
                if (b_in_valid) begin
                    b_total += int'(b_in_data);
                    b_n++;
                    if (b_in_last) b_hold = 1;
                end
            end else if (b_out_ready) begin
                b_total = 0; b_n = 0; b_hold = 0;
            end
        end
    end

    function automatic int sat(input int n, input int cw);
        int mx = (1 << cw) - 1;
        return (n > mx) ? mx : n;
    endfunction

    // Compare DUT against the model on every falling edge.
    always @(negedge clk) begin
        check("a.in_ready",  int'(a_in_ready),  int'(!a_hold));
        check("a.out_valid", int'(a_out_valid), int'(a_hold));
        check("a.out_sum",   int'(a_out_sum),   a_total % (1 << W));
        check("a.out_carry", int'(a_out_carry), int'(a_total >= (1 << W)));
        check("a.out_count", int'(a_out_count), sat(a_n, CW_A));
        check("b.in_ready",  int'(b_in_ready),  int'(!b_hold));
        check("b.out_valid", int'(b_out_valid), int'(b_hold));
        check("b.out_sum",   int'(b_out_sum),   b_total % (1 << W));
        check("b.out_carry", int'(b_out_carry), int'(b_total >= (1 << W)));
        check("b.out_count", int'(b_out_count), sat(b_n, CW_B));
    end

    // Drive one cycle on DUT A; returns 1 time unit after the edge.
    task automatic step_a(input bit v, input int d, input bit l, input bit r);
        a_in_valid  = v;
        a_in_data   = W'(d);
        a_in_last   = l;
        a_out_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic step_b(input bit v, input int d, input bit l, input bit r);
        b_in_valid  = v;
        b_in_data   = W'(d);
        b_in_last   = l;
        b_out_ready = r;
        @(posedge clk);
        #1;
    endtask

    // Literal result check on DUT A.
    task automatic expect_a(input string tag, input int v, input int s, input int c, input int n);
        check({tag, ".valid"}, int'(a_out_valid), v);
        check({tag, ".sum"},   int'(a_out_sum),   s);
        check({tag, ".carry"}, int'(a_out_carry), c);
        check({tag, ".count"}, int'(a_out_count), n);
    endtask

    initial begin
        rst = 1'b1;
        a_in_valid = 0; a_in_data = '0; a_in_last = 0; a_out_ready = 0;
        b_in_valid = 0; b_in_data = '0; b_in_last = 0; b_out_ready = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("reset.in_ready", int'(a_in_ready), 1);
        expect_a("reset", 0, 0, 0, 0);

        // 3 + 5 + 7 = 15, no wrap
        step_a(1, 3, 0, 1);
        step_a(1, 5, 0, 1);
        check("f1.not_yet_valid", int'(a_out_valid), 0);
        step_a(1, 7, 1, 1);
        expect_a("f1", 1, 'hF, 0, 3);
        step_a(0, 0, 0, 1);
        check("f1.ready_after", int'(a_in_ready), 1);

        // 0xF + 0xC = 0x1B -> sum 0xB, carry 1
        step_a(1, 'hF, 0, 0);
        step_a(1, 'hC, 1, 0);
        expect_a("f2", 1, 'hB, 1, 2);
        step_a(0, 0, 0, 1);
        step_a(1, 'h1, 1, 0);
        expect_a("f3", 1, 'h1, 0, 1);
        step_a(0, 0, 0, 1);

        // Backpressure: pending result 6 held for 5 cycles, input ignored
        step_a(1, 'h6, 1, 0);
        for (int i = 0; i < 5; i++) begin
            step_a(1, 'h2, 0, 0);
            check("bp.in_ready", int'(a_in_ready), 0);
            expect_a("bp", 1, 'h6, 0, 1);
        end
        step_a(1, 'h2, 0, 1);
        check("bp.ready_after", int'(a_in_ready), 1);
        expect_a("bp.cleared", 0, 0, 0, 0);

        // Reset mid-frame
        step_a(1, 'h4, 0, 0);
        step_a(1, 'h4, 0, 0);
        rst = 1'b1;
        step_a(0, 0, 0, 1);
        rst = 1'b0;
        expect_a("rst", 0, 0, 0, 0);
        step_a(1, 'h1, 1, 0);
        expect_a("rst.f", 1, 'h1, 0, 1);
        step_a(0, 0, 0, 1);

        // Back-to-back single-operand frames, out_ready tied high
        step_a(1, 'h2, 1, 1);
        expect_a("b2b.1", 1, 'h2, 0, 1);
        step_a(1, 'h3, 1, 1);   // handshake cycle: operand ignored
        check("b2b.gap", int'(a_out_valid), 0);
        step_a(1, 'h3, 1, 1);
        expect_a("b2b.2", 1, 'h3, 0, 1);
        step_a(0, 0, 0, 1);

        // Count saturation on CNT_W=2 instance: five 1s
        for (int i = 0; i < 5; i++) step_b(1, 'h1, (i == 4), 0);
        check("sat.valid", int'(b_out_valid), 1);
        check("sat.sum",   int'(b_out_sum),   'h5);
        check("sat.carry", int'(b_out_carry), 0);
        check("sat.count", int'(b_out_count), 3);
        step_b(0, 0, 0, 1);
        check("sat.cleared", int'(b_out_count), 0);

        step_a(0, 0, 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_add_accumulator
